rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-back arbiter for the core register file's single write port.
- Two producers share the port: ALU result path and load (memory) result path.
- Each producer gets a small FIFO with a valid/ready handshake.
- The block drives regfile wenb/rd/wdata and exports a pending-write mask for the hazard/stall logic.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, >= 2.
- MAX_WAIT, 3, consecutive cycles an ALU head may lose arbitration before it is forced through; range 1..15.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU write-back request.
- alu_ready  output  1  ALU FIFO can accept.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU write data.
- mem_valid  input  1  load write-back request.
- mem_ready  output  1  load FIFO can accept.
- mem_rd  input  5  load destination register.
- mem_data  input  32  load write data.
- rf_wenb  output  1  regfile write enable.
- rf_rd  output  5  regfile destination address.
- rf_wdata  output  32  regfile write data.
- pend_mask  output  32  bit r set while a write to x(r) is buffered.

Behaviour:
- Reset (async, immediate):
  - both FIFOs emptied; wait_cnt = 0.
  - rf_wenb = 0, rf_rd = 0, rf_wdata = 0, pend_mask = 0.
  - alu_ready = mem_ready = 1 once reset deasserts; both are 0 while reset is high.
- Handshake:
  - A transfer occurs on a rising edge with valid && ready.
  - ready = (count < DEPTH), based only on the current count. A full FIFO stays not-ready even in a cycle where it pops.
  - valid must hold with stable rd/data until accepted.
- rd = 0 requests are accepted (handshake completes) and discarded; never enqueued, never written.
- Arbitration (combinational from FIFO heads, evaluated each cycle):
  - grant_alu = alu_ne && (!mem_ne || wait_cnt == MAX_WAIT)
  - grant_mem = mem_ne && !grant_alu
  - Load path has default priority.
- Write port outputs are combinational from the granted head:
  - rf_wenb = grant_alu | grant_mem
  - rf_rd / rf_wdata = granted head's fields
  - all three are 0 when there is no grant.
- The granted head pops on the same rising edge that the regfile captures the write.
- Latency: a request accepted at edge N is written to the regfile at edge N+1 at best (empty FIFOs, no competition).
- wait_cnt:
  - increments when alu_ne && !grant_alu;
  - clears on grant_alu or when the ALU FIFO is empty;
  - saturates at MAX_WAIT.
- Ordering:
  - Each FIFO is strict in-order.
  - No ordering between sources; upstream must not issue same-rd writes on both paths concurrently.
- pend_mask:
  - combinational OR over all occupied entries of both FIFOs of one-hot(rd);
  - bit 0 is always 0;
  - a bit clears in the cycle after its last entry pops.
- Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards buffered writes; no write is issued after release.

Optional Feature:
- Macro: RF_WB_STATS_EN
- Defined:
  - adds output conflict_cnt [15:0];
  - increments, saturating at 16'hFFFF, every cycle both alu_ne and mem_ne are true;
  - cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU rd=5, data=32'hDEADBEEF accepted at edge N, mem idle -> cycle after N: rf_wenb=1, rf_rd=5, rf_wdata=DEADBEEF, pend_mask=32'h20; after edge N+1: rf_wenb=0, pend_mask=0.
- ALU rd=4/data=1 and mem rd=3/data=2 accepted on the same edge -> first write rd=3 data=2, next cycle rd=4 data=1, pend_mask 32'h18 -> 32'h10 -> 0.
- Mem streams every cycle, one ALU entry rd=7 buffered -> mem granted 3 cycles, ALU (rd=7) granted on the 4th, mem resumes after.
- Mem stream continuous, ALU pushes 3 back-to-back -> alu_ready=0 after 2 accepted; goes 1 the cycle after the first forced ALU grant.
- ALU rd=0 data=32'hFFFFFFFF -> handshake completes, rf_wenb stays 0, pend_mask stays 0.
- Two entries buffered, reset pulsed mid-cycle -> rf_wenb, pend_mask, readies drop to 0 immediately without a clock edge; no writes after release; readies = 1.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the two write-back producers, the register file write
// port and the hazard logic. The arbiter takes the slave side.
// Optional macro RF_WB_STATS_EN adds the conflict_cnt statistics signal.
interface rf_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_wenb;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
`ifdef RF_WB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, rf_wenb, rf_rd, rf_wdata, pend_mask
`ifdef RF_WB_STATS_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, rf_wenb, rf_rd, rf_wdata, pend_mask
`ifdef RF_WB_STATS_EN
    , output conflict_cnt
`endif
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: one small FIFO per producer (ALU, load),
// load path has default priority, an ALU head that keeps losing is forced
// through after MAX_WAIT cycles. Also exports the pending-write mask.
// Optional macro RF_WB_STATS_EN adds a saturating conflict_cnt output.

// Per-source FIFO holding (rd, data) pairs plus a one-hot mask of buffered rd.
module rf_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic [4:0]  i_pushRd,
  input  logic [31:0] i_pushData,
  input  logic        i_pop,
  output logic        o_ready,
  output logic        o_notEmpty,
  output logic [4:0]  o_headRd,
  output logic [31:0] o_headData,
  output logic [31:0] o_pendMask
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          w_pop;

  // Ready depends only on the current count, and is held low during reset.
  assign o_ready    = !reset && (r_count < (AW+1)'(DEPTH));
  assign o_notEmpty = (r_count != '0);
  assign w_pop      = i_pop && o_notEmpty;
  assign o_headRd   = r_rd[r_rdPtr];
  assign o_headData = r_data[r_rdPtr];

  // Payload storage; contents only matter for occupied slots, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_wrPtr]   <= i_pushRd;
      r_data[r_wrPtr] <= i_pushData;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // OR one-hot(rd) over every occupied slot, walking from the head.
  always_comb begin
    o_pendMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        o_pendMask[r_rd[r_rdPtr + AW'(i)]] = 1'b1;
      end
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset,
  rf_wb_arbiter_if.slave bus
);
  logic        w_aluReady, w_memReady;
  logic        w_aluNe, w_memNe;
  logic        w_aluPush, w_memPush;
  logic        w_grantAlu, w_grantMem;
  logic [4:0]  w_aluRd, w_memRd;
  logic [31:0] w_aluData, w_memData;
  logic [31:0] w_aluMask, w_memMask;
  logic [3:0]  r_waitCnt;

  // rd = 0 completes the handshake but is dropped instead of being enqueued.
  assign w_aluPush = bus.alu_valid && w_aluReady && (bus.alu_rd != 5'd0);
  assign w_memPush = bus.mem_valid && w_memReady && (bus.mem_rd != 5'd0);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_aluFifo (
    .clk(clk), .reset(reset),
    .i_push(w_aluPush), .i_pushRd(bus.alu_rd), .i_pushData(bus.alu_data),
    .i_pop(w_grantAlu),
    .o_ready(w_aluReady), .o_notEmpty(w_aluNe),
    .o_headRd(w_aluRd), .o_headData(w_aluData), .o_pendMask(w_aluMask)
  );

  rf_wb_fifo #(.DEPTH(DEPTH)) u_memFifo (
    .clk(clk), .reset(reset),
    .i_push(w_memPush), .i_pushRd(bus.mem_rd), .i_pushData(bus.mem_data),
    .i_pop(w_grantMem),
    .o_ready(w_memReady), .o_notEmpty(w_memNe),
    .o_headRd(w_memRd), .o_headData(w_memData), .o_pendMask(w_memMask)
  );

  // Loads win by default; a starved ALU head is forced through at MAX_WAIT.
  assign w_grantAlu = w_aluNe && (!w_memNe || (r_waitCnt == 4'(MAX_WAIT)));
  assign w_grantMem = w_memNe && !w_grantAlu;

  assign bus.alu_ready = w_aluReady;
  assign bus.mem_ready = w_memReady;
  assign bus.rf_wenb   = w_grantAlu | w_grantMem;
  assign bus.rf_rd     = w_grantAlu ? w_aluRd   : (w_grantMem ? w_memRd   : 5'd0);
  assign bus.rf_wdata  = w_grantAlu ? w_aluData : (w_grantMem ? w_memData : 32'd0);
  assign bus.pend_mask = (w_aluMask | w_memMask) & ~32'h1;

  // Count consecutive cycles the ALU head loses, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt <= 4'd0;
    end else if (!w_aluNe || w_grantAlu) begin
      r_waitCnt <= 4'd0;
    end else if (r_waitCnt != 4'(MAX_WAIT)) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

`ifdef RF_WB_STATS_EN
  logic [15:0] r_conflictCnt;

  // Count cycles where both sources hold data, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflictCnt <= 16'd0;
    end else if (w_aluNe && w_memNe && (r_conflictCnt != 16'hFFFF)) begin
      r_conflictCnt <= r_conflictCnt + 16'd1;
    end
  end

  assign bus.conflict_cnt = r_conflictCnt;
`else
  // No statistics counter in this build.
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, MAX_WAIT=3): each scenario
// drives the two producers and checks the write port against hand-worked values.
module tb_rf_wb_arbiter;
  logic clk;
  logic reset;
  int   testCount;
  int   failCount;

  rf_wb_arbiter_if bus();

  rf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive both producer request buses for the next rising edge.
  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic mV, input logic [4:0] mRd, input logic [31:0] mD);
    bus.alu_valid = aV;
    bus.alu_rd    = aRd;
    bus.alu_data  = aD;
    bus.mem_valid = mV;
    bus.mem_rd    = mRd;
    bus.mem_data  = mD;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Check the write port as a whole.
  task automatic checkWrite(input string tag, input logic en, input logic [4:0] rd,
                            input logic [31:0] data);
    checkOutput({tag, ".wenb"},  32'(bus.rf_wenb), 32'(en));
    checkOutput({tag, ".rd"},    32'(bus.rf_rd),   32'(rd));
    checkOutput({tag, ".wdata"}, bus.rf_wdata,     data);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset state: everything low while reset is held.
    #1;
    checkOutput("rst.aluReady", 32'(bus.alu_ready), 32'd0);
    checkOutput("rst.memReady", 32'(bus.mem_ready), 32'd0);
    checkWrite("rst", 1'b0, 5'd0, 32'd0);
    checkOutput("rst.pend", bus.pend_mask, 32'd0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("rel.aluReady", 32'(bus.alu_ready), 32'd1);
    checkOutput("rel.memReady", 32'(bus.mem_ready), 32'd1);

    // Single ALU write, no competition: visible the cycle after acceptance.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("single", 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("single.pend", bus.pend_mask, 32'h20);
    nextCycle();
    checkOutput("single.after.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("single.after.pend", bus.pend_mask, 32'd0);

    // Simultaneous acceptance: load first, then ALU.
    applyStimulus(1'b1, 5'd4, 32'd1, 1'b1, 5'd3, 32'd2);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("both.first", 1'b1, 5'd3, 32'd2);
    checkOutput("both.pend0", bus.pend_mask, 32'h18);
    nextCycle();
    checkWrite("both.second", 1'b1, 5'd4, 32'd1);
    checkOutput("both.pend1", bus.pend_mask, 32'h10);
    nextCycle();
    checkOutput("both.idle.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("both.pend2", bus.pend_mask, 32'd0);

    // Starvation limit: mem streams, one ALU entry forced on the 4th cycle.
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd10, 32'd10);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'd11);
    checkWrite("starve.c1", 1'b1, 5'd10, 32'd10);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'd12);
    checkWrite("starve.c2", 1'b1, 5'd11, 32'd11);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'd13);
    checkWrite("starve.c3", 1'b1, 5'd12, 32'd12);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'd14);
    checkWrite("starve.c4", 1'b1, 5'd7, 32'h77);
    checkOutput("starve.c4.pend", bus.pend_mask, 32'h2080);
    checkOutput("starve.c4.memReady", 32'(bus.mem_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkWrite("starve.c5", 1'b1, 5'd13, 32'd13);
    nextCycle();
    checkWrite("starve.c6", 1'b1, 5'd14, 32'd14);
    nextCycle();
    checkOutput("starve.idle.wenb", 32'(bus.rf_wenb), 32'd0);

    // Back-pressure: ALU FIFO fills after two pushes, frees after forced grant.
    applyStimulus(1'b1, 5'd20, 32'd20, 1'b1, 5'd1, 32'd101);
    nextCycle();
    applyStimulus(1'b1, 5'd21, 32'd21, 1'b1, 5'd2, 32'd102);
    checkOutput("bp.c1.aluReady", 32'(bus.alu_ready), 32'd1);
    checkWrite("bp.c1", 1'b1, 5'd1, 32'd101);
    nextCycle();
    applyStimulus(1'b1, 5'd22, 32'd22, 1'b1, 5'd8, 32'd108);
    checkOutput("bp.c2.aluReady", 32'(bus.alu_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd22, 32'd22, 1'b1, 5'd9, 32'd109);
    checkOutput("bp.c3.aluReady", 32'(bus.alu_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd22, 32'd22, 1'b1, 5'd12, 32'd112);
    checkWrite("bp.c4", 1'b1, 5'd20, 32'd20);
    checkOutput("bp.c4.aluReady", 32'(bus.alu_ready), 32'd0);
    nextCycle();
    checkOutput("bp.c5.aluReady", 32'(bus.alu_ready), 32'd1);
    checkOutput("bp.c5.wenb", 32'(bus.rf_wenb), 32'd1);
    checkOutput("bp.c5.alugrant", 32'(bus.rf_rd == 5'd21), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 10; i++) nextCycle();
    checkOutput("bp.drain.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("bp.drain.pend", bus.pend_mask, 32'd0);

    // rd = 0: handshake completes, nothing is written or marked pending.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    checkOutput("x0.aluReady", 32'(bus.alu_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("x0.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("x0.pend", bus.pend_mask, 32'd0);
    nextCycle();
    checkOutput("x0.later.wenb", 32'(bus.rf_wenb), 32'd0);

    // Asynchronous reset mid-cycle with two entries buffered.
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd6, 32'h66);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("arst.pendBefore", bus.pend_mask, 32'h240);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("arst.pend", bus.pend_mask, 32'd0);
    checkOutput("arst.aluReady", 32'(bus.alu_ready), 32'd0);
    checkOutput("arst.memReady", 32'(bus.mem_ready), 32'd0);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("arst.rel.aluReady", 32'(bus.alu_ready), 32'd1);
    checkOutput("arst.rel.memReady", 32'(bus.mem_ready), 32'd1);
    checkOutput("arst.rel.wenb", 32'(bus.rf_wenb), 32'd0);
    nextCycle();
    checkOutput("arst.rel2.wenb", 32'(bus.rf_wenb), 32'd0);
    checkOutput("arst.rel2.pend", bus.pend_mask, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
